// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port 320x240 RGB444 framebuffer between
// the VGA scan-out (every even active pixel, pixel-doubled 640x480) and
// game-logic writes, which use every other cycle. Scan always wins.
module vga_fb_arbiter #(
  // Power-on value of the frame counter; 0 in normal use.
  parameter logic [15:0] FRAME_CNT_RST = 16'd0
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        wr_req,
  input  logic [16:0] wr_addr,
  input  logic [11:0] wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic [16:0] mem_addr,
  output logic        mem_we,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  output logic [11:0] pixel_rgb,
  output logic        pixel_valid,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam logic [16:0] FB_WORDS = 17'd76800;

  logic [16:0] r_mem_addr;
  logic        r_mem_we;
  logic [11:0] r_mem_wdata;
  logic        r_wr_ack;
  logic        r_wr_err;
  logic [2:0]  r_valid_d;
  logic [1:0]  r_scan_d;
  logic [11:0] r_pixel_rgb;
  logic        r_frame_tick;
  logic [15:0] r_frame_cnt;

  logic [16:0] w_row;
  logic [16:0] w_scan_addr;
  logic        w_scan_slot;
  logic        w_wr_go;
  logic        w_wr_ok;
  logic        w_last_px;

  // Row index times 320 as (row<<8)+(row<<6); max 239*320+319 fits 17 bits.
  assign w_row       = {8'd0, v_cnt[9:1]};
  assign w_scan_addr = (w_row << 8) + (w_row << 6) + {8'd0, h_cnt[9:1]};

  // Even active pixels own the RAM; everything else is free for writes.
  assign w_scan_slot = valid & ~h_cnt[0];
  // An outstanding ack blocks re-issue so a held request writes once.
  assign w_wr_go     = ~w_scan_slot & wr_req & ~r_wr_ack;
  assign w_wr_ok     = (wr_addr < FB_WORDS);
  assign w_last_px   = valid & (h_cnt == 10'd639) & (v_cnt == 10'd479);

  // RAM port: scan read beats write; idle cycles keep the address.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_mem_addr  <= 17'd0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 12'd0;
    end else if (w_scan_slot) begin
      r_mem_addr  <= w_scan_addr;
      r_mem_we    <= 1'b0;
    end else if (w_wr_go && w_wr_ok) begin
      r_mem_addr  <= wr_addr;
      r_mem_wdata <= wr_data;
      r_mem_we    <= 1'b1;
    end else begin
      r_mem_we    <= 1'b0;
    end
  end

  // Write handshake: ack every consumed request, flag dropped bad addresses.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_go;
      if (w_wr_go && !w_wr_ok) begin
        r_wr_err <= 1'b1;
      end else begin
        r_wr_err <= r_wr_err;
      end
    end
  end

  // Delay valid and the scan-slot marker to line up with RAM read data.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_valid_d <= 3'd0;
      r_scan_d  <= 2'd0;
    end else begin
      r_valid_d <= {r_valid_d[1:0], valid};
      r_scan_d  <= {r_scan_d[0], w_scan_slot};
    end
  end

  // Pixel register: load read data on scan pixels, hold for the odd twin,
  // blank to zero outside active video.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_pixel_rgb <= 12'd0;
    end else if (!r_valid_d[1]) begin
      r_pixel_rgb <= 12'd0;
    end else if (r_scan_d[1]) begin
      r_pixel_rgb <= mem_rdata;
    end else begin
      r_pixel_rgb <= r_pixel_rgb;
    end
  end

  // Frame boundary: pulse and count after the last active pixel.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= FRAME_CNT_RST;
    end else begin
      r_frame_tick <= w_last_px;
      if (w_last_px) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign wr_ack      = r_wr_ack;
  assign wr_err      = r_wr_err;
  assign pixel_rgb   = r_pixel_rgb;
  assign pixel_valid = r_valid_d[2];
  assign frame_tick  = r_frame_tick;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 pclk  input  1  pixel clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on the pclk rising edge.
REQ-003 valid  input  1  active-video flag from the VGA timing controller.
REQ-004 h_cnt  input  10  pixel column, 0..639, 0 in blanking.
REQ-005 v_cnt  input  10  pixel row, 0..479, 0 in blanking.
REQ-006 wr_req  input  1  game-logic write request; held high with addr/data stable until wr_ack.
REQ-007 wr_addr  input  17  framebuffer word address, legal range 0..76799.
REQ-008 wr_data  input  12  RGB444 pixel to write.
REQ-009 wr_ack  output  1  one-cycle pulse: the request is consumed.
REQ-010 wr_err  output  1  sticky flag: an out-of-range write was acked and dropped.
REQ-011 mem_addr  output  17  registered framebuffer address.
REQ-012 mem_we  output  1  registered write enable.
REQ-013 mem_wdata  output  12  registered write data.
REQ-014 mem_rdata  input  12  single-port synchronous RAM read data, valid 1 cycle after mem_addr.
REQ-015 pixel_rgb  output  12  registered pixel to the DAC, 0 when not pixel_valid.
REQ-016 pixel_valid  output  1  valid delayed 3 cycles.
REQ-017 frame_tick  output  1  one-cycle pulse after the last active pixel of a frame.
REQ-018 frame_cnt  output  16  frames completed since reset, wraps 65535->0.

Function
REQ-019 Framebuffer is 320x240: scan address = (v_cnt>>1)*320 + (h_cnt>>1), computed without multiplier overflow in 17 bits.
REQ-020 Scan slot: a cycle with valid=1 and h_cnt[0]=0; on its following edge mem_addr<=scan address, mem_we<=0.
REQ-021 Free slot: any cycle that is not a scan slot, including all blanking cycles; scan always wins, writes never block a scan.
REQ-022 Write issue: in a free slot with wr_req=1 and wr_ack=0, the next edge sets mem_addr<=wr_addr, mem_wdata<=wr_data, mem_we<=1 and wr_ack<=1.
REQ-023 wr_ack high blocks re-issue in that cycle, so one held request yields exactly one write.
REQ-024 wr_addr>=76800 in a free slot: wr_ack pulses, mem_we stays 0, wr_err<=1 and holds until reset.
REQ-025 wr_req in a scan slot: no action; it waits for the next free slot, at most 1 cycle during active video.
REQ-026 Cycles with no scan and no write: mem_we<=0, mem_addr holds.
REQ-027 Read pipeline: scan slot at cycle N; mem_addr at edge N+1; mem_rdata valid in cycle N+2; pixel register loads it at edge N+3 and holds it for 2 pixels.
REQ-028 pixel_valid = valid delayed by a 3-stage shift register; pixel_rgb forced 0 whenever the delayed valid is 0.
REQ-029 A write to the address being scanned does not disturb that pixel's latched read data.
REQ-030 frame_tick: pulses one cycle after a cycle with valid=1, h_cnt=639, v_cnt=479; frame_cnt increments on the same edge.

Reset
REQ-031 While reset=1: mem_addr=0, mem_we=0, mem_wdata=0, wr_ack=0, wr_err=0, pixel_rgb=0, pixel_valid=0, frame_tick=0, frame_cnt=0, delay pipelines cleared.
REQ-032 A request pending at reset is dropped without ack; the requester keeps wr_req high and it is served in the first free slot after reset deasserts.
REQ-033 The first scan read after reset starts at the first scan slot; no stale pixel is output.

Verification
REQ-034 Blanking write: valid=0, wr_req=1, wr_addr=100, wr_data=0xF00 -> next edge mem_we=1, mem_addr=100, mem_wdata=0xF00, wr_ack=1 for exactly 1 cycle, one write total.
REQ-035 Scan/write contention: valid=1, h_cnt=10, v_cnt=4, wr_req=1, wr_addr=5 -> edge 1 mem_addr=645, mem_we=0; edge 2 mem_we=1, mem_addr=5, wr_ack=1.
REQ-036 Pixel latency: RAM preloaded with word 645=0xABC, scan h_cnt=10/11, v_cnt=4 -> pixel_rgb=0xABC with pixel_valid=1 for 2 cycles, 3 cycles after input; 0 in blanking.
REQ-037 Bad address: wr_addr=76800 in a free slot -> wr_ack pulse, mem_we=0, wr_err=1 until reset.
REQ-038 Frame: drive full 800x525 timing for 2 frames -> frame_tick twice, one cycle each after (639,479), frame_cnt=2; preset frame_cnt=65535 -> wraps to 0.
REQ-039 Reset mid-request: reset asserted with wr_req=1 before ack -> no ack, all outputs at reset values; after deassert -> exactly one ack and one write.
